reg_bank_32x16: RTL

- Upstream register-storage stage for the 32-to-1 16-bit operand mux. It holds 32 general registers and presents all of them in parallel on one flattened bus; the mux selects one of them.
- Register updates are applied through a single command port with a valid/ready handshake.
- Commands: write, increment, decrement, 2-cycle swap, and a sequential 32-cycle clear.

---
 rtl/reg_bank_pkg.sv | 30 +++
 rtl/reg_bank_ctrl.sv | 113 +++++++++++
 rtl/reg_bank_32x16.sv | 78 +++++++
 3 files changed

// File: rtl/reg_bank_pkg.sv
// reg_bank_pkg: shared constants and encodings for the 32x16 register bank
// and the operand mux that consumes its flattened output bus.
package reg_bank_pkg;

    localparam int WIDTH  = 16;
    localparam int NREGS  = 32;
    localparam int ADDR_W = $clog2(NREGS);
    localparam int FLAT_W = WIDTH * NREGS;

    typedef enum logic [2:0] {
        OP_NOP   = 3'd0,
        OP_WRITE = 3'd1,
        OP_INC   = 3'd2,
        OP_DEC   = 3'd3,
        OP_SWAP  = 3'd4,
        OP_CLEAR = 3'd5
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SWAP2 = 2'd1,
        ST_CLEAR = 2'd2
    } state_e;

    // Low bit of register k on the flat bus; the mux wrapper uses the same map.
    function automatic int slice_lo(int k, int w);
        return k * w;
    endfunction

endpackage

// File: rtl/reg_bank_ctrl.sv
// reg_bank_ctrl: command FSM, sequential clear counter and done pulse.
// Drives one-hot write enables plus a single write-data bus into storage.
module reg_bank_ctrl #(
    parameter int WIDTH  = 16,
    parameter int NREGS  = 32,
    parameter int ADDR_W = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cmd_valid,
    input  logic [2:0]        cmd_op,
    input  logic [ADDR_W-1:0] cmd_addr_a,
    input  logic [ADDR_W-1:0] cmd_addr_b,
    input  logic [WIDTH-1:0]  cmd_data,
    input  logic [WIDTH-1:0]  rd_a,
    input  logic [WIDTH-1:0]  rd_b,
    output logic              cmd_ready,
    output logic [NREGS-1:0]  we,
    output logic [WIDTH-1:0]  wdata,
    output logic              done
);
    import reg_bank_pkg::*;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] ctr_q, ctr_d;
    logic [ADDR_W-1:0] addr_b_q, addr_b_d;
    logic [WIDTH-1:0]  tmp_q, tmp_d;
    logic              done_q, done_d;
    logic              accept;
    logic              last;

    assign cmd_ready = (state_q == ST_IDLE);
    assign accept    = cmd_valid && cmd_ready;
    assign last      = (ctr_q == ADDR_W'(NREGS - 1));
    assign done      = done_q;

    always_comb begin
        state_d  = state_q;
        ctr_d    = ctr_q;
        addr_b_d = addr_b_q;
        tmp_d    = tmp_q;
        done_d   = 1'b0;
        we       = '0;
        wdata    = '0;
        unique case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    done_d = 1'b1;
                    unique case (cmd_op)
                        OP_WRITE: begin
                            we[cmd_addr_a] = 1'b1;
                            wdata          = cmd_data;
                        end
                        OP_INC: begin
                            we[cmd_addr_a] = 1'b1;
                            wdata          = rd_a + WIDTH'(1);
                        end
                        OP_DEC: begin
                            we[cmd_addr_a] = 1'b1;
                            wdata          = rd_a - WIDTH'(1);
                        end
                        OP_SWAP: begin
                            we[cmd_addr_a] = 1'b1;
                            wdata          = rd_b;
                            tmp_d          = rd_a;
                            addr_b_d       = cmd_addr_b;
                            state_d        = ST_SWAP2;
                            done_d         = 1'b0;
                        end
                        OP_CLEAR: begin
                            ctr_d   = '0;
                            state_d = ST_CLEAR;
                            done_d  = 1'b0;
                        end
                        default: ;
                    endcase
                end
            end
            ST_SWAP2: begin
                we[addr_b_q] = 1'b1;
                wdata        = tmp_q;
                state_d      = ST_IDLE;
                done_d       = 1'b1;
            end
            ST_CLEAR: begin
                we[ctr_q] = 1'b1;
                ctr_d     = ctr_q + ADDR_W'(1);
                if (last) begin
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            ctr_q    <= '0;
            addr_b_q <= '0;
            tmp_q    <= '0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            ctr_q    <= ctr_d;
            addr_b_q <= addr_b_d;
            tmp_q    <= tmp_d;
            done_q   <= done_d;
        end
    end

endmodule

// File: rtl/reg_bank_32x16.sv
// reg_bank_32x16: 32 x 16-bit register storage with a command port,
// presenting every register in parallel to the downstream operand mux.
module reg_bank_32x16 #(
    parameter int WIDTH    = reg_bank_pkg::WIDTH,
    parameter int NREGS    = reg_bank_pkg::NREGS,
    parameter bit ZERO_REG = 1'b0
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       cmd_valid,
    output logic                       cmd_ready,
    input  logic [2:0]                 cmd_op,
    input  logic [$clog2(NREGS)-1:0]   cmd_addr_a,
    input  logic [$clog2(NREGS)-1:0]   cmd_addr_b,
    input  logic [WIDTH-1:0]           cmd_data,
    output logic [NREGS*WIDTH-1:0]     regs_flat,
    output logic                       busy,
    output logic                       done
);
    import reg_bank_pkg::*;

    logic [WIDTH-1:0] mem [NREGS];
    logic [NREGS-1:0] we;
    logic [NREGS-1:0] we_eff;
    logic [WIDTH-1:0] wdata;
    logic [WIDTH-1:0] rd_a;
    logic [WIDTH-1:0] rd_b;

    // With a hard-wired zero register, R0 never takes a write.
    assign we_eff = ZERO_REG ? (we & ~NREGS'(1)) : we;

    assign rd_a = (ZERO_REG && cmd_addr_a == '0) ? '0 : mem[cmd_addr_a];
    assign rd_b = (ZERO_REG && cmd_addr_b == '0) ? '0 : mem[cmd_addr_b];

    assign busy = !cmd_ready;

    reg_bank_ctrl #(
        .WIDTH  (WIDTH),
        .NREGS  (NREGS),
        .ADDR_W ($clog2(NREGS))
    ) u_ctrl (
        .clk        (clk),
        .rst_n      (rst_n),
        .cmd_valid  (cmd_valid),
        .cmd_op     (cmd_op),
        .cmd_addr_a (cmd_addr_a),
        .cmd_addr_b (cmd_addr_b),
        .cmd_data   (cmd_data),
        .rd_a       (rd_a),
        .rd_b       (rd_b),
        .cmd_ready  (cmd_ready),
        .we         (we),
        .wdata      (wdata),
        .done       (done)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < NREGS; k++) begin
                mem[k] <= '0;
            end
        end else begin
            for (int k = 0; k < NREGS; k++) begin
                if (we_eff[k]) begin
                    mem[k] <= wdata;
                end
            end
        end
    end

    always_comb begin
        regs_flat = '0;
        for (int k = 0; k < NREGS; k++) begin
            regs_flat[slice_lo(k, WIDTH) +: WIDTH] = mem[k];
        end
    end

endmodule
